instr_encoder_loader: RTL and testbench

//  Write side of the instruction path. Accepts decoded fields (opcode, destination, operand regs).

---
 rtl/instr_encoder_loader_if.sv | 31 +++
 rtl/instr_encoder_loader.sv | 136 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Instruction loader bus: field-set handshake, byte write port to program memory, status.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              restart;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [2:0]        in_rd;
  logic [2:0]        in_rs1;
  logic [2:0]        in_rs2;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] word_count;
  logic              busy;
  logic              full;
  logic              err_field;

  // Producer of field sets (bench / boot loader).
  modport master (
    output restart, in_valid, in_opcode, in_rd, in_rs1, in_rs2,
    input  in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, full, err_field
  );

  // The loader itself.
  modport slave (
    input  restart, in_valid, in_opcode, in_rd, in_rs1, in_rs2,
    output in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, full, err_field
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words and writes them, high byte first,
// into byte-wide program memory at an auto-incrementing address.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_encoder_loader_if.slave  bus_io
);

  localparam logic [ADDR_W-1:0] Base     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LastWord = (ADDR_W+1)'(MEM_BYTES - 2);

  typedef enum logic [1:0] {StIdle, StWrHi, StWrLo, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              rst_pend_q, rst_pend_d;

  logic              in_ready;
  logic              legal;
  logic [7:0]        enc_lo;
  logic [ADDR_W:0]   ptr_next;

  assign in_ready = (state_q == StIdle) && !full_q && !bus_io.restart;
  assign legal    = !bus_io.in_rd[2] && (bus_io.in_rs1[2:1] == 2'b00)
                    && (bus_io.in_rs2[2:1] == 2'b00);
  // Upper byte of the machine word is always zero; only the low byte needs storing.
  assign enc_lo   = {bus_io.in_opcode, bus_io.in_rd[1:0], bus_io.in_rs2[0], bus_io.in_rs1[0]};
  assign ptr_next = {1'b0, ptr_q} + (ADDR_W+1)'(2);

  assign bus_io.in_ready   = in_ready;
  assign bus_io.mem_we     = (state_q == StWrHi) || (state_q == StWrLo);
  assign bus_io.mem_addr   = addr_q;
  assign bus_io.mem_wdata  = wdata_q;
  assign bus_io.word_count = cnt_q;
  assign bus_io.busy       = (state_q != StIdle);
  assign bus_io.full       = full_q;
  assign bus_io.err_field  = err_q;

  // Next-state: handshake, byte sequencing and pointer/count bookkeeping.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    lo_d       = lo_q;
    wdata_d    = wdata_q;
    full_d     = full_q;
    err_d      = err_q;
    rst_pend_d = rst_pend_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.restart) begin
          ptr_d  = Base;
          cnt_d  = '0;
          full_d = 1'b0;
          err_d  = 1'b0;
        end else if (bus_io.in_valid && in_ready) begin
          if (legal) begin
            lo_d       = enc_lo;
            addr_d     = ptr_q;
            wdata_d    = 8'h00;
            rst_pend_d = 1'b0;
            state_d    = StWrHi;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWrHi: begin
        addr_d  = ptr_q + ADDR_W'(1);
        wdata_d = lo_q;
        state_d = StWrLo;
        if (bus_io.restart) rst_pend_d = 1'b1;
      end
      StWrLo: begin
        state_d = StDone;
        if (bus_io.restart) rst_pend_d = 1'b1;
      end
      StDone: begin
        state_d    = StIdle;
        rst_pend_d = 1'b0;
        // A restart seen during the sequence takes effect here instead of advancing.
        if (bus_io.restart || rst_pend_q) begin
          ptr_d  = Base;
          cnt_d  = '0;
          full_d = 1'b0;
          err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (ptr_next > LastWord) begin
            full_d = 1'b1;  // pointer saturates at the last word
          end else begin
            ptr_d = ptr_next[ADDR_W-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset aborts any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= Base;
      cnt_q      <= '0;
      addr_q     <= Base;
      lo_q       <= 8'h00;
      wdata_q    <= 8'h00;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      rst_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      lo_q       <= lo_d;
      wdata_q    <= wdata_d;
      full_q     <= full_d;
      err_q      <= err_d;
      rst_pend_q <= rst_pend_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: timeline model checked every cycle plus directed literals.
module tb_instr_encoder_loader;
  localparam int unsigned AW   = 8;
  localparam int unsigned BASE = 0;
  localparam int unsigned MEMB = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int log_addr[$];
  int log_data[$];
  int acc_cyc[$];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: m_since counts edges since a legal accept (0 = nothing in flight).
  int m_ptr, m_cnt, m_since, m_lo, m_last_addr, m_last_data;
  bit m_full, m_err, m_pend, m_ok = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_ptr = BASE; m_cnt = 0; m_since = 0; m_lo = 0;
      m_last_addr = BASE; m_last_data = 0;
      m_full = 0; m_err = 0; m_pend = 0; m_ok = 1;
    end else if (m_since == 0) begin
      if (bus.restart) begin
        m_ptr = BASE; m_cnt = 0; m_full = 0; m_err = 0;
      end else if (bus.in_valid && !m_full) begin
        if (bus.in_rd <= 3 && bus.in_rs1 <= 1 && bus.in_rs2 <= 1) begin
          m_lo = int'(bus.in_opcode) * 16 + int'(bus.in_rd) * 4
                 + int'(bus.in_rs2) * 2 + int'(bus.in_rs1);
          m_since = 1;
          m_pend = 0;
        end else begin
          m_err = 1;
        end
      end
    end else begin
      if (bus.restart) m_pend = 1;
      if (m_since == 2) begin
        m_last_addr = m_ptr + 1;
        m_last_data = m_lo;
      end
      if (m_since == 3) begin
        m_since = 0;
        if (m_pend) begin
          m_ptr = BASE; m_cnt = 0; m_full = 0; m_err = 0; m_pend = 0;
        end else begin
          m_cnt++;
          if (m_ptr + 2 > int'(MEMB) - 2) m_full = 1;
          else m_ptr += 2;
        end
      end else begin
        m_since++;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("busy", int'(bus.busy), int'(m_since != 0));
      check("mem_we", int'(bus.mem_we), int'(m_since == 1 || m_since == 2));
      check("mem_addr", int'(bus.mem_addr),
            (m_since == 1) ? m_ptr : (m_since == 2) ? m_ptr + 1 : m_last_addr);
      check("mem_wdata", int'(bus.mem_wdata),
            (m_since == 1) ? 0 : (m_since == 2) ? m_lo : m_last_data);
      check("in_ready", int'(bus.in_ready), int'(m_since == 0 && !m_full && !bus.restart));
      check("full", int'(bus.full), int'(m_full));
      check("err_field", int'(bus.err_field), int'(m_err));
      check("word_count", int'(bus.word_count), m_cnt);
    end
  end

  // Byte-write and handshake monitors.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      log_addr.push_back(int'(bus.mem_addr));
      log_data.push_back(int'(bus.mem_wdata));
    end
    if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2);
    bit acc = 0;
    bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    // Scramble fields after the accept edge; the DUT must ignore them.
    bus.in_opcode = 4'hF; bus.in_rd = 3'd7; bus.in_rs1 = 3'd7; bus.in_rs2 = 3'd7;
    check("send_accepted", int'(acc), 1);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    log_addr.delete();
    log_data.delete();
    acc_cyc.delete();
  endtask

  initial begin
    bus.restart = 0; bus.in_valid = 0;
    bus.in_opcode = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    tick(2);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    check("rst_count", int'(bus.word_count), 0);
    tick(1);

    // 1: single word, opcode=1 rd=2 rs1=1 rs2=0 -> 00 then 19
    send(4'd1, 3'd2, 3'd1, 3'd0);
    tick(3);
    check("t1_nbytes", log_addr.size(), 2);
    if (log_addr.size() >= 2) begin
      check("t1_a0", log_addr[0], 0);
      check("t1_d0", log_data[0], 8'h00);
      check("t1_a1", log_addr[1], 1);
      check("t1_d1", log_data[1], 8'h19);
    end
    check("t1_count", int'(bus.word_count), 1);

    // 2 + 4: four back-to-back words fill the 8-byte memory
    do_restart();
    send(4'd0, 3'd0, 3'd0, 3'd0);
    send(4'd15, 3'd3, 3'd1, 3'd1);
    send(4'd5, 3'd1, 3'd1, 3'd0);
    send(4'd10, 3'd2, 3'd0, 3'd1);
    tick(3);
    check("t2_nbytes", log_addr.size(), 8);
    if (log_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) check("t2_addr", log_addr[i], i);
      check("t2_d1", log_data[1], 8'h00);
      check("t2_d3", log_data[3], 8'hFF);
      check("t2_d5", log_data[5], 8'h55);
      check("t2_d7", log_data[7], 8'hAA);
    end
    check("t2_naccept", acc_cyc.size(), 4);
    if (acc_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("t2_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
    check("t2_count", int'(bus.word_count), 4);
    check("t4_full", int'(bus.full), 1);
    bus.in_opcode = 4'd3; bus.in_rd = 3'd1; bus.in_valid = 1'b1;
    tick(10);
    bus.in_valid = 1'b0;
    check("t4_no_write", log_addr.size(), 8);
    check("t4_ready", int'(bus.in_ready), 0);
    check("t4_count", int'(bus.word_count), 4);

    // 3: illegal rd consumed, not written, sticky error
    do_restart();
    check("t3_full_clr", int'(bus.full), 0);
    send(4'd3, 3'd5, 3'd0, 3'd0);
    tick(3);
    check("t3_no_write", log_addr.size(), 0);
    check("t3_err", int'(bus.err_field), 1);
    send(4'd7, 3'd1, 3'd0, 3'd1);
    tick(3);
    check("t3_nbytes", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t3_a0", log_addr[0], 0);
      check("t3_d1", log_data[1], 8'h76);
    end
    check("t3_err_sticky", int'(bus.err_field), 1);

    // 5: restart during WR_HI of word 2
    do_restart();
    check("t5_err_clr", int'(bus.err_field), 0);
    send(4'd2, 3'd0, 3'd1, 3'd0);
    tick(3);
    send(4'd4, 3'd3, 3'd0, 3'd1);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    tick(2);
    check("t5_nbytes", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check("t5_a2", log_addr[2], 2);
      check("t5_a3", log_addr[3], 3);
      check("t5_d3", log_data[3], 8'h4E);
    end
    check("t5_count", int'(bus.word_count), 0);
    send(4'd1, 3'd0, 3'd1, 3'd1);
    tick(3);
    check("t5_nbytes2", log_addr.size(), 6);
    if (log_addr.size() == 6) begin
      check("t5_a4", log_addr[4], 0);
      check("t5_d5", log_data[5], 8'h13);
    end

    // 6: reset during WR_LO
    do_restart();
    send(4'd6, 3'd1, 3'd0, 3'd0);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_we", int'(bus.mem_we), 0);
    check("t6_addr", int'(bus.mem_addr), 0);
    check("t6_wdata", int'(bus.mem_wdata), 0);
    check("t6_busy", int'(bus.busy), 0);
    check("t6_count", int'(bus.word_count), 0);
    check("t6_ready", int'(bus.in_ready), 1);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
